// File: rtl/ternary_nn_pkg.sv
// Shared types and constants for the ternary neuron datapath.
// Activation encodings, accumulate FSM states and a width helper.
package ternary_nn_pkg;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_ZERO = 2'b00;
    localparam logic [1:0] ACT_NEG  = 2'b11;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

    // Ceiling log2, never below 1 so a single-chunk counter still has a bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ternary_neuron_accum_thresh.sv
// Combinational ternary threshold compare.
// The +1 test wins whenever both thresholds are satisfied.
module ternary_thresh
    import ternary_nn_pkg::*;
#(
    parameter int THR_W = 9
) (
    input  logic signed [THR_W-1:0] sum,
    input  logic signed [THR_W-1:0] thr_hi,
    input  logic signed [THR_W-1:0] thr_lo,
    output logic        [1:0]       act
);

    // Ordered compare: upper threshold first, then lower.
    always_comb begin
        act = ACT_ZERO;
        if (sum >= thr_hi) begin
            act = ACT_POS;
        end else if (sum <= thr_lo) begin
            act = ACT_NEG;
        end
    end

endmodule

// File: rtl/ternary_neuron_accum.sv
// Accumulate-and-threshold stage after the chunk popcount units.
// Sums CHUNKS (pos,neg) pairs and emits one ternary activation.
module ternary_neuron_accum
    import ternary_nn_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int CNT_W  = 5,
    parameter int ACC_W  = 8,
    parameter int THR_W  = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [CNT_W-1:0] pos_cnt,
    input  logic        [CNT_W-1:0] neg_cnt,
    input  logic signed [THR_W-1:0] thr_hi,
    input  logic signed [THR_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [1:0]       out_act,
    output logic signed [THR_W-1:0] out_sum
);

    localparam int IDX_W = clog2(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        chunk_idx_q, chunk_idx_d;
    logic [ACC_W-1:0]        acc_pos_q, acc_pos_d;
    logic [ACC_W-1:0]        acc_neg_q, acc_neg_d;
    logic                    out_valid_q, out_valid_d;
    logic [1:0]              out_act_q, out_act_d;
    logic signed [THR_W-1:0] out_sum_q, out_sum_d;

    logic [ACC_W-1:0]        pos_tot;
    logic [ACC_W-1:0]        neg_tot;
    logic signed [THR_W-1:0] sum;
    logic [1:0]              act;
    logic                    accept;

    assign pos_tot = acc_pos_q + ACC_W'(pos_cnt);
    assign neg_tot = acc_neg_q + ACC_W'(neg_cnt);
    assign sum = THR_W'($signed({1'b0, pos_tot}) - $signed({1'b0, neg_tot}));

    assign in_ready  = (state_q == ACC);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_act   = out_act_q;
    assign out_sum   = out_sum_q;

    ternary_thresh #(
        .THR_W (THR_W)
    ) u_thresh (
        .sum    (sum),
        .thr_hi (thr_hi),
        .thr_lo (thr_lo),
        .act    (act)
    );

    // Next-state: accumulate chunks, capture result on the last, hold until taken.
    always_comb begin
        state_d     = state_q;
        chunk_idx_d = chunk_idx_q;
        acc_pos_d   = acc_pos_q;
        acc_neg_d   = acc_neg_q;
        out_valid_d = out_valid_q;
        out_act_d   = out_act_q;
        out_sum_d   = out_sum_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    if (chunk_idx_q == LAST_IDX) begin
                        chunk_idx_d = '0;
                        acc_pos_d   = '0;
                        acc_neg_d   = '0;
                        out_act_d   = act;
                        out_sum_d   = sum;
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        chunk_idx_d = chunk_idx_q + IDX_W'(1);
                        acc_pos_d   = pos_tot;
                        acc_neg_d   = neg_tot;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State registers with synchronous reset dominating all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            chunk_idx_q <= '0;
            acc_pos_q   <= '0;
            acc_neg_q   <= '0;
            out_valid_q <= 1'b0;
            out_act_q   <= ACT_ZERO;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            chunk_idx_q <= chunk_idx_d;
            acc_pos_q   <= acc_pos_d;
            acc_neg_q   <= acc_neg_d;
            out_valid_q <= out_valid_d;
            out_act_q   <= out_act_d;
            out_sum_q   <= out_sum_d;
        end
    end

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Bench for ternary_neuron_accum: directed cases plus random traffic.
// Expected values come from an evaluation-level model kept here.
module tb_ternary_neuron_accum;

    localparam int CHUNKS = 4;
    localparam int CNT_W  = 5;
    localparam int ACC_W  = 8;
    localparam int THR_W  = 9;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic        [CNT_W-1:0] pos_cnt;
    logic        [CNT_W-1:0] neg_cnt;
    logic signed [THR_W-1:0] thr_hi;
    logic signed [THR_W-1:0] thr_lo;
    logic                    out_valid;
    logic                    out_ready;
    logic        [1:0]       out_act;
    logic signed [THR_W-1:0] out_sum;

    int n_tests;
    int n_fail;

    // Model: list of chunks gathered so far and the pending result.
    int m_pos[$];
    int m_neg[$];
    bit m_pending;
    int m_act;
    int m_sum;

    ternary_neuron_accum #(
        .CHUNKS (CHUNKS),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W),
        .THR_W  (THR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pos_cnt   (pos_cnt),
        .neg_cnt   (neg_cnt),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int act_of(input int s, input int hi, input int lo);
        if (s >= hi) return 1;
        if (s <= lo) return 3;
        return 0;
    endfunction

    // What one clock edge does, at the level of whole evaluations.
    task automatic model_edge(input bit r, input bit iv, input int p,
                              input int n, input int hi, input int lo,
                              input bit ordy);
        int sp;
        int sn;
        if (r) begin
            m_pos.delete();
            m_neg.delete();
            m_pending = 0;
            m_act = 0;
            m_sum = 0;
        end else if (!m_pending) begin
            if (iv) begin
                m_pos.push_back(p);
                m_neg.push_back(n);
                if (m_pos.size() == CHUNKS) begin
                    sp = 0;
                    sn = 0;
                    foreach (m_pos[i]) sp += m_pos[i];
                    foreach (m_neg[i]) sn += m_neg[i];
                    m_sum = sp - sn;
                    m_act = act_of(m_sum, hi, lo);
                    m_pending = 1;
                    m_pos.delete();
                    m_neg.delete();
                end
            end
        end else if (ordy) begin
            m_pending = 0;
        end
    endtask

    // Drive one cycle of inputs, advance model, then compare after the edge.
    task automatic step(input bit r, input bit iv, input int p, input int n,
                        input int hi, input int lo, input bit ordy);
        rst       = r;
        in_valid  = iv;
        pos_cnt   = CNT_W'(p);
        neg_cnt   = CNT_W'(n);
        thr_hi    = THR_W'(hi);
        thr_lo    = THR_W'(lo);
        out_ready = ordy;
        @(posedge clk);
        model_edge(r, iv, p, n, hi, lo, ordy);
        @(negedge clk);
        chk("in_ready", int'(in_ready), int'(!m_pending));
        chk("out_valid", int'(out_valid), int'(m_pending));
        chk("out_act", int'(out_act), m_act);
        chk("out_sum", int'(out_sum), m_sum);
    endtask

    task automatic send(input int p, input int n, input int hi, input int lo);
        step(1'b0, 1'b1, p, n, hi, lo, 1'b1);
    endtask

    task automatic send4(input int p, input int n, input int hi, input int lo);
        for (int i = 0; i < CHUNKS; i++) send(p, n, hi, lo);
        step(1'b0, 1'b0, 0, 0, hi, lo, 1'b1);
    endtask

    initial begin
        int hi;
        int lo;
        n_tests   = 0;
        n_fail    = 0;
        m_pending = 0;
        m_act     = 0;
        m_sum     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        pos_cnt   = '0;
        neg_cnt   = '0;
        thr_hi    = '0;
        thr_lo    = '0;
        out_ready = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 7, 3, 0, 0, 1'b0);

        send4(18, 0, 10, -10);
        chk("sum_72", int'(out_sum), 72);
        chk("act_pos", int'(out_act), 1);
        send4(0, 18, 10, -10);
        chk("sum_m72", int'(out_sum), -72);
        send4(9, 9, 10, -10);
        chk("act_zero", int'(out_act), 0);

        send(3, 0, 10, -10);
        send(3, 0, 10, -10);
        send(2, 0, 10, -10);
        send(2, 0, 10, -10);
        chk("hi_edge", int'(out_act), 1);
        step(1'b0, 1'b0, 0, 0, 10, -10, 1'b1);
        send(0, 3, 10, -10);
        send(0, 3, 10, -10);
        send(0, 2, 10, -10);
        send(0, 2, 10, -10);
        chk("lo_edge", int'(out_act), 3);
        step(1'b0, 1'b0, 0, 0, 10, -10, 1'b1);
        send4(3, 0, 5, 20);
        chk("priority", int'(out_act), 1);

        for (int i = 0; i < CHUNKS; i++) step(1'b0, 1'b1, 5, 1, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, i[0], 31, 0, 100, -100, 1'b0);
        chk("bp_sum", int'(out_sum), 16);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("bp_release", int'(in_ready), 1);

        send4(31, 0, 10, -10);
        chk("sum_124", int'(out_sum), 124);
        send4(0, 31, 10, -10);
        chk("sum_m124", int'(out_sum), -124);

        send(18, 0, 10, -10);
        send(18, 0, 10, -10);
        step(1'b1, 1'b0, 0, 0, 10, -10, 1'b1);
        send4(1, 0, 10, -10);
        chk("rst_discard", int'(out_sum), 4);

        for (int i = 0; i < 400; i++) begin
            hi = int'($urandom_range(260)) - 130;
            lo = int'($urandom_range(260)) - 130;
            step(($urandom_range(49) == 0), $urandom_range(3) != 0,
                 int'($urandom_range(31)), int'($urandom_range(31)),
                 hi, lo, $urandom_range(2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
